// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory end of the core's load/store interface. One request at a time is
//   taken over a valid/ready handshake, optionally delayed by WAIT_CYCLES wait
//   states, and answered over a second valid/ready handshake.
//   Stores merge byte/half/word data into the addressed lanes.
//   Loads return the addressed byte/half/word, sign- or zero-extended.
//   Misaligned, illegal-size or out-of-range accesses respond with rsp_err=1,
//   rsp_rdata=0, and never write the array.
//
// Parameters
//   ADDR_W       word-address bits; the array holds 2**ADDR_W 32-bit words
//   WAIT_CYCLES  wait states between accept and response (0..15)
//
// Ports
//   clk           clock, all state on the rising edge
//   reset         asynchronous, active-low reset
//   req_valid     request present
//   req_ready     responder can accept a request this cycle
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   rsp_valid     response present
//   rsp_ready     core accepts the response
//   rsp_rdata     extended load data; 0 for stores and errors
//   rsp_err       misaligned, illegal size or out-of-range access
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  // state  | meaning
  // -------+-------------------------------------------------------------
  // S_IDLE | ready for a request; req_ready=1
  // S_WAIT | request latched, counting down wait states
  // S_RESP | response held on rsp_* until rsp_ready; array already accessed
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state;
  logic [3:0]  wait_cnt;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  // Request fields as seen at the commit edge. With no wait states the commit
  // edge is the accept edge, so the live inputs are used directly; otherwise
  // the copy latched at accept.
  logic        acc_we;
  logic [1:0]  acc_size;
  logic        acc_unsigned;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  logic              acc_err;
  logic [ADDR_W-1:0] acc_idx;
  logic              enter_resp;
  logic              wr_en;
  logic [3:0]        wr_be;
  logic [31:0]       wr_lanes;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic [31:0]       rsp_rdata_nxt;

  logic [31:0] mem [2**ADDR_W];

  always_comb begin
    if (state == S_IDLE) begin
      acc_we       = req_we;
      acc_size     = req_size;
      acc_unsigned = req_unsigned;
      acc_addr     = req_addr;
      acc_wdata    = req_wdata;
    end else begin
      acc_we       = lat_we;
      acc_size     = lat_size;
      acc_unsigned = lat_unsigned;
      acc_addr     = lat_addr;
      acc_wdata    = lat_wdata;
    end
  end

  assign acc_idx = acc_addr[ADDR_W+1:2];

  always_comb begin
    acc_err = 1'b0;
    if (acc_size == 2'b11)                                  acc_err = 1'b1;
    if ((acc_size == SZ_HALF) && acc_addr[0])               acc_err = 1'b1;
    if ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00))  acc_err = 1'b1;
    if (acc_addr[31:ADDR_W+2] != '0)                        acc_err = 1'b1;
  end

  // The array is touched only on the edge that enters S_RESP, so a reset
  // during S_WAIT drops a pending store without side effects.
  assign enter_resp = ((state == S_IDLE) && req_valid && NO_WAIT) ||
                      ((state == S_WAIT) && (wait_cnt == 4'd0));
  assign wr_en      = enter_resp && acc_we && !acc_err;

  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = acc_wdata;
    case (acc_size)
      SZ_BYTE: begin
        wr_lanes = {4{acc_wdata[7:0]}};
        case (acc_addr[1:0])
          2'd0:    wr_be = 4'b0001;
          2'd1:    wr_be = 4'b0010;
          2'd2:    wr_be = 4'b0100;
          default: wr_be = 4'b1000;
        endcase
      end
      SZ_HALF: begin
        wr_lanes = {2{acc_wdata[15:0]}};
        wr_be    = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: wr_be = 4'b1111;
      default: wr_be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[acc_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[acc_idx];

  always_comb begin
    case (acc_addr[1:0])
      2'd0:    rd_byte = rd_word[7:0];
      2'd1:    rd_byte = rd_word[15:8];
      2'd2:    rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];
  end

  always_comb begin
    case (acc_size)
      SZ_BYTE: load_ext = acc_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      SZ_HALF: load_ext = acc_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  assign rsp_rdata_nxt = (acc_we || acc_err) ? 32'd0 : load_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wait_cnt     <= 4'd0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      lat_we       <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            req_ready    <= 1'b0;
            if (NO_WAIT) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rsp_rdata_nxt;
              rsp_err   <= acc_err;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= acc_err;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
